pixel_stream_rr_arbiter: RTL and testbench

//  Shares one pixel_concat input port between NUM_SRC pixel streams.

---
 rtl/pixel_stream_rr_arbiter_pkg.sv | 18 +
 rtl/pixel_stream_rr_arbiter_if.sv | 43 ++++
 rtl/pixel_stream_rr_arbiter_skid.sv | 77 +++++++
 rtl/pixel_stream_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_pixel_stream_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_rr_arbiter_pkg.sv
// Shared constants and helpers for the pixel stream round-robin arbiter.
// Arbiter FSM encodings and a width helper used by all arbiter files.
package pixel_stream_rr_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_stream_rr_arbiter_if.sv
// Source-side and pixel_concat-side signals of the arbiter.
// master: sources plus pixel_concat; slave: the arbiter itself.
interface pixel_stream_rr_arbiter_if
  import pixel_stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DAT_WIDTH = 32
) ();

  localparam int SW = clog2(NUM_SRC);

  logic [NUM_SRC*DAT_WIDTH-1:0] src_dat;
  logic [NUM_SRC-1:0]           src_val;
  logic [NUM_SRC-1:0]           src_stall;
  logic [DAT_WIDTH-1:0]         odat;
  logic                         oval;
  logic [SW-1:0]                osrc;
  logic                         osof;
  logic                         istall;

  modport master (
    output src_dat,
    output src_val,
    output istall,
    input  src_stall,
    input  odat,
    input  oval,
    input  osrc,
    input  osof
  );

  modport slave (
    input  src_dat,
    input  src_val,
    input  istall,
    output src_stall,
    output odat,
    output oval,
    output osrc,
    output osof
  );

endinterface

// File: rtl/pixel_stream_rr_arbiter_skid.sv
// Two-entry skid buffer in front of one arbiter input.
// Absorbs the extra word a registered-stall source sends.
module pixel_skid_buf #(
  parameter int DAT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DAT_WIDTH-1:0] push_dat,
  input  logic                 pop,
  output logic [1:0]           cnt,
  output logic [DAT_WIDTH-1:0] head,
  output logic                 stall
);

  logic [1:0]           cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0] m0_q, m0_d;
  logic [DAT_WIDTH-1:0] m1_q, m1_d;
  logic                 pop_ok;

  assign pop_ok = pop && (cnt_q != 2'd0);

  // Next occupancy and storage; a push into a full
  // buffer without a pop is dropped.
  always_comb begin
    cnt_d = cnt_q;
    m0_d  = m0_q;
    m1_d  = m1_q;
    case ({push, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          m0_d  = push_dat;
          cnt_d = 2'd1;
        end else if (cnt_q == 2'd1) begin
          m1_d  = push_dat;
          cnt_d = 2'd2;
        end
      end
      2'b01: begin
        m0_d  = m1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          m0_d = push_dat;
        end else begin
          m0_d = m1_q;
          m1_d = push_dat;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      m0_q  <= '0;
      m1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
    end
  end

  assign cnt   = cnt_q;
  assign head  = m0_q;
  assign stall = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop_ok);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && (cnt_q == 2'd2) && !pop_ok)
  );

endmodule

// File: rtl/pixel_stream_rr_arbiter.sv
// Round-robin burst arbiter feeding one pixel_concat port.
// Per-source skid buffers, IDLE/GRANT scheduler, registered output.
module pixel_stream_rr_arbiter
  import pixel_stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DAT_WIDTH = 32,
  parameter int BURST_LEN = 8
) (
  input logic                     clk,
  input logic                     rst,
  pixel_stream_rr_arbiter_if.slave bus
);

  localparam int SW = clog2(NUM_SRC);
  localparam int BW = clog2(BURST_LEN + 1);
  localparam logic [SW-1:0] LAST_SRC  = SW'(NUM_SRC - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [1:0]           cnt  [NUM_SRC];
  logic [DAT_WIDTH-1:0] head [NUM_SRC];
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   pop;
  logic [NUM_SRC-1:0]   stall;

  logic [0:0]           state_q, state_d;
  logic [SW-1:0]        gnt_q, gnt_d;
  logic [SW-1:0]        ptr_q, ptr_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;

  logic [DAT_WIDTH-1:0] odat_q, odat_d;
  logic                 oval_q, oval_d;
  logic [SW-1:0]        osrc_q, osrc_d;
  logic                 osof_q, osof_d;

  logic [SW-1:0]        hit;
  logic [SW-1:0]        scan_idx;
  logic                 found;
  logic                 pop_any;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_buf
    pixel_skid_buf #(
      .DAT_WIDTH (DAT_WIDTH)
    ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (bus.src_val[i]),
      .push_dat (bus.src_dat[i*DAT_WIDTH +: DAT_WIDTH]),
      .pop      (pop[i]),
      .cnt      (cnt[i]),
      .head     (head[i]),
      .stall    (stall[i])
    );
    assign req[i] = (cnt[i] != 2'd0);
  end

  assign bus.src_stall = stall;

  // Pick the first non-empty buffer at or after ptr, wrapping.
  always_comb begin
    hit      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = SW'((int'(ptr_q) + k) % NUM_SRC);
      if (!found && req[scan_idx]) begin
        hit   = scan_idx;
        found = 1'b1;
      end
    end
  end

  // Only the granted buffer pops, and only while downstream is ready.
  always_comb begin
    pop_any = (state_q == ARB_GRANT) && req[gnt_q] && !bus.istall;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = pop_any && (gnt_q == SW'(i));
    end
  end

  // Grant scheduler: claim a source, run its burst, release.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          gnt_d   = hit;
          ptr_d   = (hit == LAST_SRC) ? '0 : hit + 1'b1;
          bcnt_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (pop_any) bcnt_d = bcnt_q + 1'b1;
        if ((pop_any && (bcnt_q == LAST_BEAT)) ||
            (!req[gnt_q] && !bus.src_val[gnt_q])) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output stage: one cycle behind the pop that produced it.
  always_comb begin
    oval_d = pop_any;
    osrc_d = gnt_q;
    osof_d = pop_any && (bcnt_q == '0);
    odat_d = pop_any ? head[gnt_q] : odat_q;
  end

  // Scheduler and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      odat_q  <= '0;
      oval_q  <= 1'b0;
      osrc_q  <= '0;
      osof_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      odat_q  <= odat_d;
      oval_q  <= oval_d;
      osrc_q  <= osrc_d;
      osof_q  <= osof_d;
    end
  end

  assign bus.odat = odat_q;
  assign bus.oval = oval_q;
  assign bus.osrc = osrc_q;
  assign bus.osof = osof_q;

endmodule

// File: tb/tb_pixel_stream_rr_arbiter.sv
// Bench for pixel_stream_rr_arbiter: directed phases with random
// gaps/stalls, checked against per-source word queues and RR rules.
module tb_pixel_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst;

  pixel_stream_rr_arbiter_if #(.NUM_SRC(N), .DAT_WIDTH(DW)) bus ();

  pixel_stream_rr_arbiter #(
    .NUM_SRC   (N),
    .DAT_WIDTH (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sq [N][$];
  int            seq    [N];
  int            remain [N];
  bit            active [N];
  int            gap_pct;
  int            smode;
  logic [15:0]   fc;
  logic [N-1:0]  stall_prev;
  logic [N-1:0]  stall_now;
  logic          istall_cyc;
  int            cyc;
  int            last_cyc;
  int            cur_src;
  int            cur_len;
  bit            have_burst;
  int            bsrc [$];
  int            blen [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int s = 0; s < N; s++) if (sq[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic observe();
    int s;
    bit must;
    logic [DW-1:0] w;
    if (bus.oval === 1'b1) begin
      s = int'(bus.osrc);
      check("pop_while_istall", istall_cyc, 0);
      check("word_outstanding", sq[s].size() > 0, 1);
      if (sq[s].size() > 0) begin
        w = sq[s].pop_front();
        check("odat", bus.odat, w);
      end
      must = !have_burst || (s != cur_src) || (cur_len >= BL);
      if (must) check("osof_needed", bus.osof, 1);
      if (bus.osof === 1'b1) begin
        if (have_burst) check("release_bubble", (cyc - last_cyc) >= 2, 1);
        bsrc.push_back(s);
        blen.push_back(1);
        cur_len = 1;
      end else begin
        cur_len++;
        if (blen.size() > 0)
          blen[blen.size()-1] = blen[blen.size()-1] + 1;
      end
      cur_src    = s;
      have_burst = 1'b1;
      last_cyc   = cyc;
    end else begin
      check("osof_idle", bus.osof, 0);
    end
  endtask

  task automatic drive();
    logic [DW-1:0] w;
    fc++;
    case (smode)
      0:       bus.istall = 1'b0;
      1:       bus.istall = fc[1] | fc[5] | fc[11];
      default: bus.istall = 1'($urandom_range(1));
    endcase
    for (int s = 0; s < N; s++) begin
      bus.src_val[s] = 1'b0;
      if (active[s] && remain[s] > 0 && !stall_prev[s] &&
          $urandom_range(99) >= gap_pct) begin
        w = (s << 24) | (seq[s] & 32'h00FF_FFFF);
        bus.src_dat[s*DW +: DW] = w;
        bus.src_val[s] = 1'b1;
        sq[s].push_back(w);
        seq[s]++;
        remain[s]--;
      end
    end
  endtask

  task automatic tick();
    #1;
    stall_now  = bus.src_stall;
    istall_cyc = bus.istall;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) observe();
    stall_prev = stall_now;
    drive();
  endtask

  task automatic do_reset(input string tag);
    for (int s = 0; s < N; s++) active[s] = 1'b0;
    bus.src_val = '0;
    bus.istall  = 1'b0;
    smode       = 0;
    gap_pct     = 0;
    rst         = 1'b1;
    tick();
    check({tag, "_oval"},  bus.oval, 0);
    check({tag, "_odat"},  bus.odat, 0);
    check({tag, "_osrc"},  bus.osrc, 0);
    check({tag, "_osof"},  bus.osof, 0);
    check({tag, "_stall"}, bus.src_stall, 0);
    rst = 1'b0;
    for (int s = 0; s < N; s++) sq[s].delete();
    bsrc.delete();
    blen.delete();
    have_burst = 1'b0;
    cur_len    = 0;
    stall_prev = '0;
  endtask

  task automatic drain(input string tag);
    for (int s = 0; s < N; s++) active[s] = 1'b0;
    smode = 0;
    for (int i = 0; i < 400; i++) begin
      if (all_empty()) break;
      tick();
    end
    repeat (3) tick();
    for (int s = 0; s < N; s++) check({tag, "_drained"}, sq[s].size(), 0);
  endtask

  task automatic start(input int s, input int n);
    active[s] = 1'b1;
    remain[s] = n;
  endtask

  initial begin
    rst         = 1'b1;
    bus.src_dat = '0;
    bus.src_val = '0;
    bus.istall  = 1'b0;
    fc          = '0;
    cyc         = 0;
    last_cyc    = 0;
    cur_src     = 0;
    stall_prev  = '0;
    for (int s = 0; s < N; s++) begin
      seq[s]    = 0;
      remain[s] = 0;
      active[s] = 1'b0;
    end

    // power-on reset state
    do_reset("por");

    // 1: single continuous source
    start(0, 1000);
    repeat (80) tick();
    drain("t1");
    check("t1_bursts", bsrc.size() >= 5, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < bsrc.size()) begin
        check("t1_src", bsrc[i], 0);
        check("t1_len", blen[i], BL);
      end
    end

    // 2: all sources continuous, strict rotation
    do_reset("t2rst");
    for (int s = 0; s < N; s++) start(s, 1000);
    repeat (130) tick();
    drain("t2");
    check("t2_bursts", bsrc.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < bsrc.size()) begin
        check("t2_src", bsrc[i], rr_pick(i % N, 4'hF));
        check("t2_len", blen[i], BL);
      end
    end

    // 3: free-counter stall pattern, then random stalls, random gaps
    do_reset("t3rst");
    for (int s = 0; s < N; s++) start(s, 100000);
    gap_pct = 30;
    smode   = 1;
    repeat (600) tick();
    smode = 2;
    repeat (300) tick();
    drain("t3");

    // 4: source 2 stops after 3 words while granted
    do_reset("t4rst");
    start(2, 3);
    start(3, 100);
    repeat (40) tick();
    drain("t4");
    check("t4_bursts", bsrc.size() >= 2, 1);
    if (bsrc.size() >= 2) begin
      check("t4_first_src", bsrc[0], 2);
      check("t4_first_len", blen[0], 3);
      check("t4_next_src", bsrc[1], rr_pick((2 + 1) % N, 4'b1000));
    end

    // 5: ptr at 2, sources 1 and 3 arrive together
    do_reset("t5rst");
    start(1, 1);
    repeat (10) tick();
    start(1, 2);
    start(3, 2);
    repeat (20) tick();
    drain("t5");
    check("t5_bursts", bsrc.size() >= 3, 1);
    if (bsrc.size() >= 3) begin
      check("t5_setup_src", bsrc[0], 1);
      check("t5_first_src", bsrc[1], rr_pick((1 + 1) % N, 4'b1010));
      check("t5_second_src", bsrc[2], rr_pick((3 + 1) % N, 4'b0010));
    end

    // 6: reset in the middle of a burst
    do_reset("t6rst");
    for (int s = 0; s < N; s++) start(s, 1000);
    repeat (14) tick();
    do_reset("t6mid");
    for (int s = 0; s < N; s++) start(s, 1000);
    repeat (30) tick();
    drain("t6");
    check("t6_bursts", bsrc.size() >= 1, 1);
    if (bsrc.size() >= 1) check("t6_restart_src", bsrc[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
